// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time against a local word array, fixed
// access latency, stalls the core until the single-cycle Done_o pulse.
`timescale 1ns/1ps
module load_store_unit #(
   parameter int          DATA_MEMORY_DEPTH = 128,
   parameter int          MEM_LATENCY       = 2,
   parameter logic [31:0] BASE_ADDR         = 32'h1001_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Mem_Read_i,
   input  logic        Mem_Write_i,
   input  logic [2:0]  Funct3_i,
   input  logic [31:0] Address_i,
   input  logic [31:0] Write_Data_i,
   output logic [31:0] Read_Data_o,
   output logic        Stall_o,
   output logic        Done_o,
   output logic        Fault_o
);
   localparam int          IW        = (DATA_MEMORY_DEPTH > 1) ? $clog2(DATA_MEMORY_DEPTH) : 1;
   localparam logic [31:0] MEM_BYTES = 32'(4 * DATA_MEMORY_DEPTH);
   localparam logic [2:0]  LAT_M1    = 3'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   typedef struct packed {
      logic          we;
      logic [2:0]    f3;
      logic [1:0]    lane;
      logic [IW-1:0] idx;
      logic [31:0]   wdata;
   } req_t;

   state_t      state;
   logic [2:0]  cnt;
   req_t        r, nxt_req;
   logic        req, illegal, commit;
   logic [31:0] off, rd_word, wr_word, ld_data;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] mem [DATA_MEMORY_DEPTH];

   assign req     = Mem_Read_i | Mem_Write_i;
   assign off     = Address_i - BASE_ADDR;
   assign Stall_o = ((state == IDLE) && req) || (state == ACCESS);
   assign commit  = (state == ACCESS) && (cnt == 3'd0);

   assign nxt_req.we    = Mem_Write_i;
   assign nxt_req.f3    = Funct3_i;
   assign nxt_req.lane  = Address_i[1:0];
   assign nxt_req.idx   = off[IW+1:2];
   assign nxt_req.wdata = Write_Data_i;

   always_comb begin
      illegal = 1'b0;
      if (Mem_Read_i && Mem_Write_i)
         illegal = 1'b1;
      else if (Mem_Read_i && (Funct3_i == 3'd3 || Funct3_i == 3'd6 || Funct3_i == 3'd7))
         illegal = 1'b1;
      else if (Mem_Write_i && (Funct3_i > 3'd2))
         illegal = 1'b1;
      if ((Funct3_i[1:0] == 2'd1) && Address_i[0])
         illegal = 1'b1;
      if ((Funct3_i[1:0] == 2'd2) && (Address_i[1:0] != 2'd0))
         illegal = 1'b1;
      // Unsigned compare also catches addresses below BASE_ADDR via wraparound.
      if (off >= MEM_BYTES)
         illegal = 1'b1;
   end

   assign rd_word = mem[r.idx];

   always_comb begin
      byte_sel = rd_word[{r.lane, 3'b000} +: 8];
      half_sel = rd_word[{r.lane[1], 4'b0000} +: 16];
      case (r.f3[1:0])
         2'd0:    ld_data = {{24{~r.f3[2] & byte_sel[7]}}, byte_sel};
         2'd1:    ld_data = {{16{~r.f3[2] & half_sel[15]}}, half_sel};
         default: ld_data = rd_word;
      endcase
      // Stores merge the new lanes into the current word.
      wr_word = rd_word;
      case (r.f3[1:0])
         2'd0:    wr_word[{r.lane, 3'b000} +: 8]   = r.wdata[7:0];
         2'd1:    wr_word[{r.lane[1], 4'b0000} +: 16] = r.wdata[15:0];
         default: wr_word = r.wdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= 3'd0;
         r           <= '0;
         Read_Data_o <= 32'd0;
         Done_o      <= 1'b0;
         Fault_o     <= 1'b0;
      end else begin
         Done_o  <= 1'b0;
         Fault_o <= 1'b0;
         case (state)
            IDLE: begin
               if (req) begin
                  if (illegal) begin
                     state       <= DONE;
                     Done_o      <= 1'b1;
                     Fault_o     <= 1'b1;
                     Read_Data_o <= 32'd0;
                  end else begin
                     state <= ACCESS;
                     cnt   <= LAT_M1;
                     r     <= nxt_req;
                  end
               end
            end
            ACCESS: begin
               if (cnt == 3'd0) begin
                  state  <= DONE;
                  Done_o <= 1'b1;
                  if (!r.we)
                     Read_Data_o <= ld_data;
               end else begin
                  cnt <= cnt - 3'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array has no reset: contents survive a reset, and an aborted access never commits.
   always_ff @(posedge clk) begin
      if (commit && r.we)
         mem[r.idx] <= wr_word;
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence and
// random traffic against a byte-level memory model.
`timescale 1ns/1ps
module tb_load_store_unit;
   localparam int          DEPTH = 128;
   localparam int          LAT   = 2;
   localparam logic [31:0] BASE  = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        Mem_Read_i, Mem_Write_i;
   logic [2:0]  Funct3_i;
   logic [31:0] Address_i, Write_Data_i;
   logic [31:0] Read_Data_o;
   logic        Stall_o, Done_o, Fault_o;

   int n_cmp = 0;
   int n_err = 0;

   load_store_unit #(.DATA_MEMORY_DEPTH(DEPTH), .MEM_LATENCY(LAT), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset),
      .Mem_Read_i(Mem_Read_i), .Mem_Write_i(Mem_Write_i), .Funct3_i(Funct3_i),
      .Address_i(Address_i), .Write_Data_i(Write_Data_i),
      .Read_Data_o(Read_Data_o), .Stall_o(Stall_o), .Done_o(Done_o), .Fault_o(Fault_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      bit          wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] e_rd;
      bit          e_fault;
   } vec_t;

   // Reference model: flat little-endian byte array plus last load result.
   logic [7:0]  ref_bytes [4*DEPTH];
   logic [31:0] m_rd;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void model(input bit rd, input bit wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd, output bit fault);
      logic [31:0] off, val;
      int n;
      off   = addr - BASE;
      n     = 1 << f3[1:0];
      fault = 1'b0;
      if (rd && wr) fault = 1'b1;
      if (rd && !wr && (f3 == 3 || f3 == 6 || f3 == 7)) fault = 1'b1;
      if (wr && !rd && f3 > 2) fault = 1'b1;
      if (n == 2 && (addr % 2) != 0) fault = 1'b1;
      if (n == 4 && (addr % 4) != 0) fault = 1'b1;
      if (off >= 4*DEPTH) fault = 1'b1;
      if (fault) begin
         m_rd = 32'd0;
      end else if (wr) begin
         for (int i = 0; i < n; i++) ref_bytes[int'(off) + i] = wd[8*i +: 8];
      end else begin
         val = 32'd0;
         for (int i = 0; i < n; i++) val = val | (32'(ref_bytes[int'(off) + i]) << (8*i));
         if (!f3[2] && n < 4 && val[8*n-1]) val = val - (32'd1 << (8*n));
         m_rd = val;
      end
   endfunction

   task automatic idle_in();
      Mem_Read_i = 1'b0; Mem_Write_i = 1'b0; Funct3_i = 3'd0;
      Address_i = 32'd0; Write_Data_i = 32'd0;
   endtask

   task automatic garbage_in();
      Mem_Read_i   = 1'($urandom);
      Mem_Write_i  = 1'($urandom);
      Funct3_i     = 3'($urandom);
      Address_i    = $urandom;
      Write_Data_i = $urandom;
   endtask

   // Starts at a negedge in IDLE, ends at a negedge in IDLE with inputs idle.
   task automatic run_op(input string tag, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] e_rd, input bit e_fault);
      int stalls;
      bit seen;
      Mem_Read_i = rd; Mem_Write_i = wr; Funct3_i = f3; Address_i = addr; Write_Data_i = wd;
      #1;
      stalls = Stall_o ? 1 : 0;
      seen   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (Done_o) begin
            seen = 1'b1;
            break;
         end
         if (Stall_o) stalls++;
         garbage_in();
      end
      chk({tag, " done_seen"}, 32'(seen), 32'd1);
      chk({tag, " stalls"}, stalls, e_fault ? 1 : 1 + LAT);
      chk({tag, " fault"}, 32'(Fault_o), 32'(e_fault));
      chk({tag, " rdata"}, Read_Data_o, e_rd);
      chk({tag, " stall_in_done"}, 32'(Stall_o), 32'd0);
      garbage_in();
      @(negedge clk);
      idle_in();
      #1;
      chk({tag, " done_pulse"}, {Done_o, Fault_o, Stall_o}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[$];
      bit   f;
      int   sel;
      logic [2:0]  rf3;
      logic [31:0] raddr;
      logic [31:0] rwd;
      bit          rrd, rwr;

      vt.push_back('{1'b0, 1'b1, 3'd2, 32'h1001_0004, 32'h1122_3344, 32'h0000_0000, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_0004, 32'h0,         32'h1122_3344, 1'b0});
      vt.push_back('{1'b0, 1'b1, 3'd0, 32'h1001_0005, 32'h0000_00AB, 32'h1122_3344, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_0004, 32'h0,         32'h1122_AB44, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd0, 32'h1001_0005, 32'h0,         32'hFFFF_FFAB, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd4, 32'h1001_0005, 32'h0,         32'h0000_00AB, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd1, 32'h1001_0006, 32'h0,         32'h0000_1122, 1'b0});
      vt.push_back('{1'b0, 1'b1, 3'd1, 32'h1001_0006, 32'hFFFF_8001, 32'h0000_1122, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd1, 32'h1001_0006, 32'h0,         32'hFFFF_8001, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd5, 32'h1001_0006, 32'h0,         32'h0000_8001, 1'b0});
      vt.push_back('{1'b0, 1'b1, 3'd0, 32'h1001_0007, 32'h1234_565A, 32'h0000_8001, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_0004, 32'h0,         32'h5A01_AB44, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd1, 32'h1001_0005, 32'h0,         32'h0000_0000, 1'b1});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_0004, 32'h0,         32'h5A01_AB44, 1'b0});
      vt.push_back('{1'b0, 1'b1, 3'd2, 32'h1001_0200, 32'h7777_7777, 32'h0000_0000, 1'b1});
      vt.push_back('{1'b1, 1'b1, 3'd2, 32'h1001_0004, 32'h9999_9999, 32'h0000_0000, 1'b1});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_0004, 32'h0,         32'h5A01_AB44, 1'b0});
      vt.push_back('{1'b0, 1'b1, 3'd2, 32'h1001_01FC, 32'hCAFE_F00D, 32'h5A01_AB44, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_01FC, 32'h0,         32'hCAFE_F00D, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1000_FFFC, 32'h0,         32'h0000_0000, 1'b1});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_0006, 32'h0,         32'h0000_0000, 1'b1});
      vt.push_back('{1'b0, 1'b1, 3'd3, 32'h1001_0004, 32'h0,         32'h0000_0000, 1'b1});
      vt.push_back('{1'b1, 1'b0, 3'd6, 32'h1001_0004, 32'h0,         32'h0000_0000, 1'b1});
      vt.push_back('{1'b1, 1'b0, 3'd3, 32'h1001_0004, 32'h0,         32'h0000_0000, 1'b1});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_0004, 32'h0,         32'h5A01_AB44, 1'b0});
      vt.push_back('{1'b0, 1'b1, 3'd2, 32'h1001_0000, 32'h0BAD_F00D, 32'h5A01_AB44, 1'b0});
      vt.push_back('{1'b1, 1'b0, 3'd2, 32'h1001_0000, 32'h0,         32'h0BAD_F00D, 1'b0});

      // Reset state.
      m_rd  = 32'd0;
      reset = 1'b0;
      idle_in();
      @(negedge clk);
      @(negedge clk);
      chk("rst read_data", Read_Data_o, 32'd0);
      chk("rst done", 32'(Done_o), 32'd0);
      chk("rst fault", 32'(Fault_o), 32'd0);
      chk("rst stall", 32'(Stall_o), 32'd0);
      reset = 1'b1;
      @(negedge clk);

      foreach (vt[i]) begin
         model(vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wd, f);
         run_op($sformatf("vec%0d", i), vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr, vt[i].wd,
                vt[i].e_rd, vt[i].e_fault);
      end

      // Reset in the second ACCESS cycle of a store: outputs clear, no commit.
      Mem_Write_i = 1'b1; Funct3_i = 3'd2; Address_i = BASE; Write_Data_i = 32'hDEAD_BEEF;
      #1;
      chk("abort stall_start", 32'(Stall_o), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("abort in_access", 32'(Stall_o), 32'd1);
      reset = 1'b0;
      idle_in();
      #1;
      chk("abort read_data", Read_Data_o, 32'd0);
      chk("abort flags", {Stall_o, Done_o, Fault_o}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      m_rd  = 32'd0;
      // Request present at the first edge after release is accepted.
      model(1'b1, 1'b0, 3'd2, BASE, 32'd0, f);
      run_op("after_abort_lw", 1'b1, 1'b0, 3'd2, BASE, 32'd0, 32'h0BAD_F00D, 1'b0);
      chk("model_agrees", m_rd, 32'h0BAD_F00D);

      // Fill the array, then random traffic.
      for (int w = 0; w < DEPTH; w++) begin
         rwd = $urandom;
         model(1'b0, 1'b1, 3'd2, BASE + 32'(4*w), rwd, f);
         run_op($sformatf("fill%0d", w), 1'b0, 1'b1, 3'd2, BASE + 32'(4*w), rwd, m_rd, f);
      end
      for (int k = 0; k < 250; k++) begin
         sel = $urandom_range(0, 9);
         rrd = (sel <= 5);
         rwr = (sel == 0) || (sel > 5);
         if ($urandom_range(0, 9) < 7) begin
            sel = $urandom_range(0, 4);
            rf3 = rwr && !rrd ? 3'(sel % 3) : ((sel < 3) ? 3'(sel) : 3'(sel + 1));
         end else begin
            rf3 = 3'($urandom);
         end
         raddr = ($urandom_range(0, 9) == 0) ? $urandom : BASE + 32'($urandom_range(0, 4*DEPTH - 1));
         rwd   = $urandom;
         model(rrd, rwr, rf3, raddr, rwd, f);
         run_op($sformatf("rnd%0d", k), rrd, rwr, rf3, raddr, rwd, m_rd, f);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DATA_MEMORY_DEPTH, default 128: number of 32-bit words in the data array.
REQ-002 SHALL have parameter MEM_LATENCY, default 2: access cycles, legal range 1..7.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1001_0000: byte address of word 0.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port Mem_Read_i, input, 1: load request from control.
REQ-007 SHALL have port Mem_Write_i, input, 1: store request from control.
REQ-008 SHALL have port Funct3_i, input, 3: access size and signedness (RV32I load/store encoding).
REQ-009 SHALL have port Address_i, input, 32: byte address (ALU result).
REQ-010 SHALL have port Write_Data_i, input, 32: store data (rs2).
REQ-011 SHALL have port Read_Data_o, output, 32: extended load result.
REQ-012 SHALL have port Stall_o, output, 1: high means core must hold PC and instruction.
REQ-013 SHALL have port Done_o, output, 1: one-cycle pulse at completion.
REQ-014 SHALL have port Fault_o, output, 1: one-cycle pulse, concurrent with Done_o, on a rejected access.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, DONE; req = Mem_Read_i | Mem_Write_i.
REQ-016 IDLE: SHALL sample Address_i, Write_Data_i, Funct3_i and request type on an edge with req=1; legal -> ACCESS with counter = MEM_LATENCY-1; illegal -> DONE with fault flag set.
REQ-017 ACCESS: counter SHALL decrement each cycle; on the edge where counter = 0 -> DONE; ACCESS lasts exactly MEM_LATENCY cycles.
REQ-018 DONE: SHALL last one cycle, assert Done_o, ignore all inputs, then -> IDLE.
REQ-019 Stall_o SHALL be combinational: (IDLE & req) | ACCESS; 0 in DONE.
REQ-020 Legal access: 1+MEM_LATENCY stall cycles then DONE; rejected access: 1 stall cycle then DONE.
REQ-021 Request illegal if: both Mem_Read_i and Mem_Write_i high; load Funct3 in {3,6,7}; store Funct3 > 2; halfword with addr[0]=1; word with addr[1:0]!=0; (Address_i - BASE_ADDR) >= 4*DATA_MEMORY_DEPTH, unsigned.
REQ-022 Word index SHALL be (Address_i - BASE_ADDR)[31:2]; byte lane = addr[1:0], little-endian.
REQ-023 Store SHALL commit on the edge ACCESS -> DONE: SB writes lane addr[1:0] only, SH writes halfword addr[1] only, SW writes all 4 bytes.
REQ-024 Load SHALL register Read_Data_o on the edge ACCESS -> DONE: LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-025 Read_Data_o SHALL hold until the next load completes; stores leave it unchanged; rejected access sets it to 0.
REQ-026 Rejected access SHALL not read or modify the array.
REQ-027 Inputs changing during ACCESS/DONE SHALL have no effect.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, counter 0, fault flag 0, Read_Data_o 0, Done_o 0, Fault_o 0.
REQ-029 Reset during ACCESS SHALL abort the access; no write commits; the data array is not cleared.
REQ-030 After reset release, a req present at the first edge SHALL be accepted normally.

Verification (defaults)
REQ-031 SW 0x11223344 @0x10010004, then LW @0x10010004 -> each stalls 3 cycles, Done_o on 4th; Read_Data_o=0x11223344.
REQ-032 SB 0x000000AB @0x10010005 -> LW @0x10010004 = 0x1122AB44; LB @0x10010005 = 0xFFFFFFAB; LBU = 0x000000AB.
REQ-033 LH @0x10010006 -> 0x00001122; LH @0x10010005 -> 1 stall cycle, Done_o=Fault_o=1, Read_Data_o=0.
REQ-034 SW @0x10010200 (out of range) and Mem_Read_i=Mem_Write_i=1 -> Fault_o pulse, array unchanged.
REQ-035 SW 0xDEADBEEF @0x10010000 with reset=0 during 2nd ACCESS cycle -> outputs 0 immediately; later LW @0x10010000 returns prior value.
